if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID register of the 5-stage RV32I pipeline.
- Owns the fetch PC and issues single-outstanding requests to a variable-latency instruction memory.
- Buffers returned {pc, instr} pairs in a small FIFO and presents the FIFO head to decode.
- Honours decode stalls and branch/jump redirects (flushes) from EX.

Parameters:
PC_W, 9, fetch address width (byte address, word-aligned)
INS_W, 32, instruction width
DEPTH, 4, FIFO entries (power of two, >= 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
imem_req  out  1  one-cycle request pulse; imem_addr valid in the same cycle
imem_addr  out  PC_W  word-aligned fetch address
imem_rvalid  in  1  response valid; arrives >= 1 cycle after imem_req
imem_rdata  in  INS_W  instruction data, qualified by imem_rvalid
id_valid  out  1  FIFO head valid toward IF/ID
id_pc  out  PC_W  PC of head entry
id_instr  out  INS_W  instruction of head entry
id_stall  in  1  decode stall; hold head, no dequeue
redirect  in  1  flush plus new fetch target (taken branch/jal/jalr)
redirect_pc  in  PC_W  new fetch PC; bits [1:0] ignored and forced to 0

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: fetch_pc=0, FIFO empty, state=IDLE, imem_req=0, imem_addr=0, id_valid=0, id_pc=0, id_instr=0.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding, response will be kept.
  - DROP: one request outstanding, response will be discarded.
- Issue condition, evaluated each cycle:
  - state is IDLE, or state is WAIT with imem_rvalid=1;
  - redirect=0;
  - count + (imem_rvalid accepted this cycle ? 1 : 0) < DEPTH. Dequeue in the same cycle earns no credit.
- On issue: imem_req=1, imem_addr=fetch_pc, fetch_pc += 4 (wraps modulo 2^PC_W), next state=WAIT.
- Transitions:
  - WAIT with rvalid and no reissue -> IDLE.
  - WAIT with redirect -> DROP, unless rvalid arrives in that same cycle; then -> IDLE.
  - DROP with rvalid -> IDLE. The response is discarded and no request is issued in that cycle.
  - imem_rvalid seen in IDLE is ignored.
- Enqueue: in WAIT with imem_rvalid=1 and redirect=0, push {pc of request, imem_rdata}. The pc of each request is latched at issue.
- Outputs:
  - id_valid = !empty && !redirect.
  - id_pc/id_instr = head entry when non-empty, else 0. Zero instr is the pipeline bubble encoding.
  - Combinational from FIFO registers and redirect.
- Dequeue: id_valid=1 and id_stall=0 pops the head at the clock edge. Back-to-back dequeue gives 1 instr/cycle.
- Redirect, for one cycle:
  - FIFO is cleared at the edge (count=0, pointers=0).
  - fetch_pc=redirect_pc with [1:0]=00.
  - No request is issued in the redirect cycle; the first request to the new target goes out the next cycle if the state is IDLE.
  - Any enqueue or dequeue in that cycle is cancelled.
- Redirect during DROP: fetch_pc is updated again and the state stays DROP.
- Redirect with id_stall=1: the flush wins.
- Throughput: with latency-1 memory, after the first response, sustained 1 request and 1 enqueue per cycle.
  - First instruction after reset: id_valid=1 no earlier than 2 cycles after reset deasserts (issue cycle, then response cycle edge).
- Full FIFO: no issue. Overflow is impossible by the credit rule. An assertion fires if enqueue occurs with count==DEPTH.
- Empty with id_stall=1: no effect.
- Reset mid-operation: returns everything to reset values. A late imem_rvalid arriving after reset is ignored (state is IDLE).

Test Plan:
- Reset release, memory latency 1, memory holds word i at addr 4i, id_stall=0 -> imem_addr 0,4,8,12,… on consecutive cycles; id_valid high from cycle 2 with id_pc 0,4,8… and matching id_instr, one per cycle.
- id_stall=1 held for 10 cycles, latency 1 -> at most DEPTH=4 entries buffered; imem_req stops; head id_pc unchanged. On release, 4 buffered entries drain in order, then fetch resumes with no gap or duplicate PC.
- Latency 3, redirect with redirect_pc=0x41 while WAIT -> state DROP; stale response not enqueued; next request has imem_addr=0x40; first id_pc after redirect =0x40.
- redirect coincident with imem_rvalid and non-empty FIFO -> id_valid=0 that cycle; FIFO empty next cycle; response dropped; next cycle imem_req with redirect target.
- fetch_pc=0x1FC, continuous fetch -> next imem_addr=0x000 (wrap); id_pc sequence 0x1FC, 0x000.
- Assert reset while WAIT (latency 4) and let the response arrive after reset -> outputs at reset values; late rvalid ignored; first post-reset imem_addr=0.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response plus the IF/ID-facing
// head-of-queue outputs and the decode stall / EX redirect controls.
interface if_fetch_queue_if #(
   parameter int unsigned PC_W  = 9,
   parameter int unsigned INS_W = 32
);
   logic             imem_req;
   logic [PC_W-1:0]  imem_addr;
   logic             imem_rvalid;
   logic [INS_W-1:0] imem_rdata;
   logic             id_valid;
   logic [PC_W-1:0]  id_pc;
   logic [INS_W-1:0] id_instr;
   logic             id_stall;
   logic             redirect;
   logic [PC_W-1:0]  redirect_pc;

   // Fetch queue side.
   modport master (
      output imem_req, imem_addr, id_valid, id_pc, id_instr,
      input  imem_rvalid, imem_rdata, id_stall, redirect, redirect_pc
   );

   // Memory / pipeline side.
   modport slave (
      input  imem_req, imem_addr, id_valid, id_pc, id_instr,
      output imem_rvalid, imem_rdata, id_stall, redirect, redirect_pc
   );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one request in
// flight to a variable-latency instruction memory, buffers {pc, instr} pairs in
// a small FIFO and presents the head to decode. EX redirects flush everything.
module if_fetch_queue #(
   parameter int unsigned PC_W  = 9,
   parameter int unsigned INS_W = 32,
   parameter int unsigned DEPTH = 4
) (
   input logic              clk,
   input logic              reset,
   if_fetch_queue_if.master bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // StWait keeps the response, StDrop discards it (redirected while in flight).
   typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

   state_e           state_q, state_d;
   logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]  req_pc_q, req_pc_d;
   logic [PC_W-1:0]  fifo_pc_q    [DEPTH];
   logic [INS_W-1:0] fifo_instr_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W:0]   credit;
   logic             empty, enq, deq, issue;

   // Handshake decode; a same-cycle dequeue earns no credit toward issuing.
   always_comb begin
      empty  = (count_q == '0);
      enq    = (state_q == StWait) && bus.imem_rvalid && !bus.redirect;
      deq    = !empty && !bus.redirect && !bus.id_stall;
      credit = {1'b0, count_q} + (CNT_W + 1)'(enq);
      issue  = !reset && !bus.redirect && ((state_q == StIdle) || enq) &&
               (credit < (CNT_W + 1)'(DEPTH));
   end

   // Next fetch PC, request PC and request-tracking state.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      if (issue) begin
         fetch_pc_d = fetch_pc_q + PC_W'(4);
         req_pc_d   = fetch_pc_q;
      end
      if (bus.redirect) begin
         fetch_pc_d = {bus.redirect_pc[PC_W-1:2], 2'b00};
      end
      case (state_q)
         StIdle: if (issue) state_d = StWait;
         StWait: begin
            if (bus.imem_rvalid) begin
               state_d = issue ? StWait : StIdle;
            end else if (bus.redirect) begin
               state_d = StDrop;
            end
         end
         StDrop: if (bus.imem_rvalid) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FIFO pointer/count update; a redirect clears the queue and cancels push/pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
      end
   end

   // Outputs; an empty queue presents pc 0 / instr 0 (pipeline bubble).
   always_comb begin
      bus.imem_req  = issue;
      bus.imem_addr = issue ? fetch_pc_q : '0;
      bus.id_valid  = !empty && !bus.redirect;
      bus.id_pc     = empty ? '0 : fifo_pc_q[rd_ptr_q];
      bus.id_instr  = empty ? '0 : fifo_instr_q[rd_ptr_q];
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         fetch_pc_q <= '0;
         req_pc_q   <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage; contents are only meaningful below count_q.
   always_ff @(posedge clk) begin
      if (enq && !reset) begin
         fifo_pc_q[wr_ptr_q]    <= req_pc_q;
         fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
      end
   end

   // The issue credit rule must make overflow unreachable.
   assert property (@(posedge clk) disable iff (reset) !(enq && count_q == CNT_W'(DEPTH)))
      else $error("if_fetch_queue: enqueue into full FIFO");
endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a latency-programmable memory model
// answers requests; a queue-based reference model predicts the FIFO contents
// and request stream; a negedge monitor compares the DUT against it.
module tb_if_fetch_queue;
   localparam int unsigned PC_W  = 9;
   localparam int unsigned INS_W = 32;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   if_fetch_queue_if #(.PC_W(PC_W), .INS_W(INS_W)) bus ();

   if_fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [INS_W-1:0] mem [128];
   int unsigned      lat = 1;

   // Reference model: expected FIFO contents and request bookkeeping.
   logic [PC_W+INS_W-1:0] exp_q [$];
   logic [PC_W-1:0]       m_fetch_pc = '0;
   logic [PC_W-1:0]       m_req_pc = '0;
   bit                    m_busy = 0;
   bit                    m_drop = 0;

   // Negedge snapshots consumed at the following posedge.
   bit               s_reset = 1;
   bit               s_req = 0;
   bit               s_issue = 0;
   bit               s_rvalid = 0;
   bit               s_redirect = 0;
   logic [PC_W-1:0]  s_addr = '0;
   logic [PC_W-1:0]  s_rpc = '0;
   logic [INS_W-1:0] s_rdata = '0;

   // Memory model state.
   bit               pend = 0;
   int unsigned      cnt = 0;
   logic [PC_W-1:0]  maddr = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit rst, input bit st, input bit rd, input logic [PC_W-1:0] rpc);
      @(posedge clk);
      #1;
      reset           = rst;
      bus.id_stall    = st;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
   endtask

   // Monitor: compare DUT outputs against the model, pop on dequeue.
   always @(negedge clk) begin
      bit                    acc;
      bit                    ev;
      logic [PC_W+INS_W-1:0] head;
      s_reset    = reset;
      s_req      = bus.imem_req;
      s_addr     = bus.imem_addr;
      s_rvalid   = bus.imem_rvalid;
      s_rdata    = bus.imem_rdata;
      s_redirect = bus.redirect;
      s_rpc      = bus.redirect_pc;
      s_issue    = 0;
      if (!reset) begin
         acc     = m_busy && !m_drop && bus.imem_rvalid;
         s_issue = !bus.redirect && (!m_busy || acc) &&
                   (exp_q.size() + int'(acc) < int'(DEPTH));
         ev      = (exp_q.size() != 0) && !bus.redirect;
         check("id_valid", 64'(bus.id_valid), 64'(ev));
         if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("id_pc", 64'(bus.id_pc), 64'(head[PC_W+INS_W-1:INS_W]));
            check("id_instr", 64'(bus.id_instr), 64'(head[INS_W-1:0]));
         end else begin
            check("bubble_pc", 64'(bus.id_pc), 64'd0);
            check("bubble_instr", 64'(bus.id_instr), 64'd0);
         end
         check("imem_req", 64'(bus.imem_req), 64'(s_issue));
         if (s_issue) check("imem_addr", 64'(bus.imem_addr), 64'(m_fetch_pc));
         if (ev && !bus.id_stall) void'(exp_q.pop_front());
      end
   end

   // Model update at the clock edge: push kept responses, apply redirects/issues.
   always @(posedge clk) begin
      if (s_reset) begin
         exp_q.delete();
         m_fetch_pc = '0;
         m_req_pc   = '0;
         m_busy     = 0;
         m_drop     = 0;
      end else begin
         if (m_busy && !m_drop && s_rvalid && !s_redirect) exp_q.push_back({m_req_pc, s_rdata});
         if (m_busy && s_rvalid) begin
            m_busy = 0;
            m_drop = 0;
         end
         if (s_redirect) begin
            exp_q.delete();
            m_fetch_pc = {s_rpc[PC_W-1:2], 2'b00};
            if (m_busy) m_drop = 1;
         end else if (s_issue) begin
            m_busy     = 1;
            m_drop     = 0;
            m_req_pc   = m_fetch_pc;
            m_fetch_pc = m_fetch_pc + PC_W'(4);
         end
      end
   end

   // Instruction memory: answers each request after lat cycles; garbage data otherwise.
   always @(posedge clk) begin
      #1;
      bus.imem_rvalid = 0;
      bus.imem_rdata  = $urandom;
      if (s_req) begin
         pend  = 1;
         cnt   = lat;
         maddr = s_addr;
      end
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            bus.imem_rvalid = 1;
            bus.imem_rdata  = mem[maddr[8:2]];
            pend            = 0;
         end
      end
   end

   initial begin
      bit found;
      for (int i = 0; i < 128; i++) mem[i] = $urandom;
      bus.id_stall    = 0;
      bus.redirect    = 0;
      bus.redirect_pc = '0;
      repeat (3) step(1, 0, 0, '0);

      // Sequential fetch, latency 1.
      lat = 1;
      repeat (20) step(0, 0, 0, '0);
      // Long decode stall then drain.
      repeat (10) step(0, 1, 0, '0);
      repeat (15) step(0, 0, 0, '0);
      // Redirect while a latency-3 request is in flight; low bits ignored.
      lat = 3;
      repeat (5) step(0, 0, 0, '0);
      step(0, 0, 1, 9'h041);
      repeat (15) step(0, 0, 0, '0);
      // Redirect coincident with a response and a non-empty, stalled FIFO.
      lat = 1;
      repeat (3) step(0, 1, 0, '0);
      step(0, 1, 1, 9'h100);
      repeat (10) step(0, 0, 0, '0);
      // PC wrap at the top of the address space.
      step(0, 0, 1, 9'h1FC);
      repeat (10) step(0, 0, 0, '0);

      // Reset while a latency-4 request is outstanding; response lands after reset.
      lat   = 4;
      found = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.imem_req) begin
            found = 1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL req_wait: got no request expected one within 20 cycles");
      end
      repeat (3) step(1, 0, 0, '0);
      lat = 1;
      repeat (10) step(0, 0, 0, '0);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         lat = $urandom_range(1, 4);
         step(0, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, PC_W'($urandom));
      end
      repeat (10) step(0, 0, 0, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
